// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state types and index helper for the FFT output reorder stage
package fft_pkg;

  localparam int N_PTS = 16;
  localparam int LOG2N = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;
  typedef enum logic {W_FILL = 1'b0, W_WAIT = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] idx);
    return {idx[0], idx[1], idx[2], idx[3]};
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// rtl/fft_reorder_bank.sv - one frame of storage: synchronous write port, combinational read port
module fft_reorder_bank #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong buffer turning bit-reversed FFT results into a natural-order stream
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_PTS  = 16,
  parameter int LOG2N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_idx,
  output logic              out_last,
  output logic              ovf_err,
  input  logic              err_clr
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_PTS - 1);

  wr_state_t         w_state, w_next;
  rd_state_t         r_state, r_next;
  bank_state_t       bank_st [2];
  logic              wr_bank, rd_bank;
  logic [LOG2N-1:0]  wr_cnt, rd_cnt;
  logic              accept, fill_now, xfer, drain_now;
  logic [2*DATA_W-1:0] rdata [2];

  assign in_ready  = (w_state == W_FILL);
  assign accept    = in_valid && in_ready;
  assign fill_now  = accept && (wr_cnt == LAST);
  assign out_valid = (r_state == R_DRAIN);
  assign xfer      = out_valid && out_ready;
  assign drain_now = xfer && (rd_cnt == LAST);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .W     (2 * DATA_W),
      .DEPTH (N_PTS),
      .AW    (LOG2N)
    ) u_bank (
      .clk   (clk),
      .we    (accept && (wr_bank == 1'(b))),
      .waddr (bitrev4(wr_cnt)),
      .wdata ({in_re, in_im}),
      .raddr (rd_cnt),
      .rdata (rdata[b])
    );
  end

  assign {out_re, out_im} = out_valid ? rdata[rd_bank] : '0;
  assign out_idx  = rd_cnt;
  assign out_last = out_valid && (rd_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state    <= W_FILL;
      r_state    <= R_IDLE;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      ovf_err    <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (fill_now) begin
        bank_st[wr_bank] <= FULL;
        wr_bank          <= ~wr_bank;
      end
      if (xfer) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      // A fill and a drain never target the same bank, so both updates can land together.
      if (drain_now) begin
        bank_st[rd_bank] <= EMPTY;
        rd_bank          <= ~rd_bank;
      end
      if (in_valid && !in_ready) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_FILL: begin
        // Stall only if the next bank will still hold an undrained frame after this edge.
        if (fill_now && (bank_st[~wr_bank] == FULL) && !(drain_now && (rd_bank != wr_bank))) begin
          w_next = W_WAIT;
        end
      end
      W_WAIT: begin
        if ((bank_st[wr_bank] == EMPTY) || (drain_now && (rd_bank == wr_bank))) begin
          w_next = W_FILL;
        end
      end
      default: w_next = W_FILL;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: begin
        if ((bank_st[rd_bank] == FULL) || (fill_now && (wr_bank == rd_bank))) begin
          r_next = R_DRAIN;
        end
      end
      R_DRAIN: begin
        // Carry straight into the next frame when it is already complete or completes this cycle.
        if (drain_now && !((bank_st[~rd_bank] == FULL) || (fill_now && (wr_bank != rd_bank)))) begin
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb/tb_fft_out_reorder.sv - directed scoreboard bench for fft_out_reorder
module tb_fft_out_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        ovf_err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  fft_out_reorder #(.DATA_W(16), .N_PTS(16), .LOG2N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf_err   (ovf_err),
    .err_clr   (err_clr)
  );

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
  } exp_t;

  logic [31:0] src_q [$];
  exp_t        exp_q [$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  logic        s_in_valid, s_in_ready, s_out_valid;
  logic [15:0] s_out_re;
  logic [3:0]  s_out_idx;

  function automatic logic [3:0] tb_bitrev(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // kind 0: re = bitrev(n)*3 + base, im = base ^ n; kind 1: re = 0x7FFF - n, im = -n
  task automatic push_frame(input int kind, input int base);
    logic [31:0] nat [16];
    logic [15:0] re, im;
    for (int n = 0; n < 16; n++) begin
      if (kind == 0) begin
        re = 16'(int'(tb_bitrev(4'(n))) * 3 + base);
        im = 16'(base ^ n);
      end else begin
        re = 16'(32'h7FFF - n);
        im = 16'(-n);
      end
      src_q.push_back({re, im});
      nat[tb_bitrev(4'(n))] = {re, im};
    end
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({nat[k][31:16], nat[k][15:0], 4'(k)});
    end
  endtask

  task automatic step(input bit want_in, input int rdy_pct);
    exp_t e;
    in_valid = want_in && (src_q.size() != 0);
    if (src_q.size() != 0) {in_re, in_im} = src_q[0];
    out_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    s_in_valid  = in_valid;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_re    = out_re;
    s_out_idx   = out_idx;
    chk("last_vs_idx", out_last, out_valid && (out_idx == 4'd15));
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_re", out_re, e.re);
        chk("out_im", out_im, e.im);
        chk("out_idx", out_idx, e.idx);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all(input string tag, input int budget, input int rdy_pct);
    for (int c = 0; c < budget && (exp_q.size() != 0 || src_q.size() != 0); c++) step(1, rdy_pct);
    chk(tag, exp_q.size() + src_q.size(), 0);
  endtask

  initial begin
    int early, drops, gaps, acc0, acc_before, sz;
    bit started, pending;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_out_data", {out_re, out_im}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single frame and first-output latency
    push_frame(0, 0);
    early = 0;
    for (int c = 0; c < 40 && src_q.size() != 0; c++) begin
      step(1, 100);
      if (s_out_valid) early++;
    end
    chk("single_early_valid", early, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_latency_valid", out_valid, 1);
    chk("single_latency_idx", out_idx, 0);
    @(posedge clk); #1;
    drain_all("single_drained", 40, 100);
    @(negedge clk);
    chk("single_idle_after", out_valid, 0);
    @(posedge clk); #1;

    // three back-to-back frames
    push_frame(0, 100);
    push_frame(0, 200);
    push_frame(0, 300);
    drops = 0; gaps = 0; started = 0;
    for (int c = 0; c < 120 && exp_q.size() != 0; c++) begin
      step(1, 100);
      if (s_in_valid && !s_in_ready) drops++;
      if (started && !s_out_valid && exp_q.size() != 0) gaps++;
      if (s_out_valid) started = 1;
    end
    chk("b2b_drained", exp_q.size(), 0);
    chk("b2b_in_ready_drops", drops, 0);
    chk("b2b_out_gaps", gaps, 0);

    // backpressure: two frames written while the consumer stalls
    push_frame(0, 500);
    push_frame(0, 600);
    acc0 = n_acc;
    for (int c = 0; c < 40; c++) begin
      acc_before = n_acc - acc0;
      step(1, 0);
      if (acc_before >= 16) begin
        chk("bp_hold_valid", s_out_valid, 1);
        chk("bp_hold_idx", s_out_idx, 0);
        chk("bp_hold_re", s_out_re, exp_q[0].re);
      end
    end
    chk("bp_accepts", n_acc - acc0, 32);
    chk("bp_in_ready_low", s_in_ready, 0);
    chk("bp_ovf_before", ovf_err, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_ovf_set", ovf_err, 1);
    in_valid = 1'b1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ovf_set_wins", ovf_err, 1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("ovf_cleared", ovf_err, 0);
    pending = 0;
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      sz = exp_q.size();
      step(0, 100);
      if (pending) begin
        chk("bp_ready_return", s_in_ready, 1);
        pending = 0;
      end
      if (sz == 17 && exp_q.size() == 16) begin
        chk("bp_ready_at_drain", s_in_ready, 0);
        pending = 1;
      end
    end
    chk("bp_drained", exp_q.size(), 0);

    // random consumer with signed pattern
    push_frame(1, 0);
    push_frame(1, 0);
    drain_all("rand_drained", 400, 50);

    // reset in the middle of a frame, with another frame pending drain
    push_frame(0, 700);
    for (int c = 0; c < 30 && src_q.size() != 0; c++) step(1, 0);
    push_frame(0, 800);
    for (int c = 0; c < 9; c++) step(1, 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_idx", out_idx, 0);
    chk("mid_rst_out_data", {out_re, out_im}, 0);
    chk("mid_rst_out_last", out_last, 0);
    src_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_frame(1, 0);
    early = 0;
    for (int c = 0; c < 40 && src_q.size() != 0; c++) begin
      step(1, 100);
      if (s_out_valid) early++;
    end
    chk("post_rst_no_early_valid", early, 0);
    drain_all("post_rst_drained", 40, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
